// File: rtl/triangle_vertex_ctrl.sv
// Triangle vertex controller: debounced pushbuttons translate three vertices once per frame.
// Define DEBOUNCE_EN to include the per-key debouncers; otherwise keys are only synchronized.
module triangle_vertex_ctrl #(
  parameter int STEP            = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int XMIN            = 285,
  parameter int XMAX            = 1554,
  parameter int YMIN            = 35,
  parameter int YMAX            = 514,
  parameter int P1X0            = 300,
  parameter int P1Y0            = 100,
  parameter int P2X0            = 400,
  parameter int P2Y0            = 300,
  parameter int P3X0            = 600,
  parameter int P3Y0            = 200
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [3:0]         KEY,
  input  logic               frame_start,
  output logic signed [25:0] p1_x,
  output logic signed [25:0] p1_y,
  output logic signed [25:0] p2_x,
  output logic signed [25:0] p2_y,
  output logic signed [25:0] p3_x,
  output logic signed [25:0] p3_y,
  output logic               updated
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic signed [25:0] STEP_S = 26'(STEP);
  localparam logic signed [25:0] XMIN_S = 26'(XMIN);
  localparam logic signed [25:0] XMAX_S = 26'(XMAX);
  localparam logic signed [25:0] YMIN_S = 26'(YMIN);
  localparam logic signed [25:0] YMAX_S = 26'(YMAX);

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] stable;
  logic [3:0] pressed;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_reg <= 4'b1111;
      sync2_reg <= 4'b1111;
    end else begin
      sync1_reg <= KEY;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_reg;
      logic             stable_reg;

      // A level must disagree for DEBOUNCE_CYCLES+1 consecutive samples before it is accepted.
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          cnt_reg    <= '0;
          stable_reg <= 1'b1;
        end else if (sync2_reg[gi] != stable_reg) begin
          if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES)) begin
            stable_reg <= sync2_reg[gi];
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else begin
          cnt_reg <= '0;
        end
      end

      assign stable[gi] = stable_reg;
    end
  endgenerate
`else
  assign stable = sync2_reg;
`endif

  assign pressed = ~stable;

  logic [1:0]         state_reg;
  logic [3:0]         dir_reg;
  logic signed [25:0] dx_reg, dy_reg;
  logic signed [25:0] dx_next, dy_next;
  logic signed [25:0] p1_x_reg, p1_y_reg, p2_x_reg, p2_y_reg, p3_x_reg, p3_y_reg;
  logic               updated_reg;

  logic signed [25:0] minx, maxx, miny, maxy;
  logic signed [25:0] head_r, head_l, head_d, head_u;
  logic signed [25:0] step_r, step_l, step_d, step_u;

  // Bounding box and clamped per-direction moves for the current vertices.
  always_comb begin
    minx = p1_x_reg;
    maxx = p1_x_reg;
    miny = p1_y_reg;
    maxy = p1_y_reg;
    if (p2_x_reg < minx) minx = p2_x_reg;
    if (p3_x_reg < minx) minx = p3_x_reg;
    if (p2_x_reg > maxx) maxx = p2_x_reg;
    if (p3_x_reg > maxx) maxx = p3_x_reg;
    if (p2_y_reg < miny) miny = p2_y_reg;
    if (p3_y_reg < miny) miny = p3_y_reg;
    if (p2_y_reg > maxy) maxy = p2_y_reg;
    if (p3_y_reg > maxy) maxy = p3_y_reg;

    head_r = XMAX_S - maxx;
    head_l = minx - XMIN_S;
    head_d = YMAX_S - maxy;
    head_u = miny - YMIN_S;
    if (head_r < 0) head_r = '0;
    if (head_l < 0) head_l = '0;
    if (head_d < 0) head_d = '0;
    if (head_u < 0) head_u = '0;

    step_r = (head_r < STEP_S) ? head_r : STEP_S;
    step_l = (head_l < STEP_S) ? head_l : STEP_S;
    step_d = (head_d < STEP_S) ? head_d : STEP_S;
    step_u = (head_u < STEP_S) ? head_u : STEP_S;

    dx_next = '0;
    if (dir_reg[0] && !dir_reg[1]) dx_next = step_r;
    else if (dir_reg[1] && !dir_reg[0]) dx_next = -step_l;

    dy_next = '0;
    if (dir_reg[2] && !dir_reg[3]) dy_next = step_d;
    else if (dir_reg[3] && !dir_reg[2]) dy_next = -step_u;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg   <= ST_WAIT;
      dir_reg     <= '0;
      dx_reg      <= '0;
      dy_reg      <= '0;
      p1_x_reg    <= 26'(P1X0);
      p1_y_reg    <= 26'(P1Y0);
      p2_x_reg    <= 26'(P2X0);
      p2_y_reg    <= 26'(P2Y0);
      p3_x_reg    <= 26'(P3X0);
      p3_y_reg    <= 26'(P3Y0);
      updated_reg <= 1'b0;
    end else begin
      updated_reg <= 1'b0;
      case (state_reg)
        ST_WAIT: begin
          if (frame_start) begin
            dir_reg   <= pressed;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          dx_reg    <= dx_next;
          dy_reg    <= dy_next;
          state_reg <= ST_COMMIT;
        end
        ST_COMMIT: begin
          p1_x_reg    <= p1_x_reg + dx_reg;
          p2_x_reg    <= p2_x_reg + dx_reg;
          p3_x_reg    <= p3_x_reg + dx_reg;
          p1_y_reg    <= p1_y_reg + dy_reg;
          p2_y_reg    <= p2_y_reg + dy_reg;
          p3_y_reg    <= p3_y_reg + dy_reg;
          updated_reg <= (dx_reg != 0) || (dy_reg != 0);
          state_reg   <= ST_WAIT;
        end
        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  assign p1_x    = p1_x_reg;
  assign p1_y    = p1_y_reg;
  assign p2_x    = p2_x_reg;
  assign p2_y    = p2_y_reg;
  assign p3_x    = p3_x_reg;
  assign p3_y    = p3_y_reg;
  assign updated = updated_reg;

endmodule

// File: tb/tb_triangle_vertex_ctrl.sv
// Bench for triangle_vertex_ctrl: cycle-level reference model plus directed and random frames.
module tb_triangle_vertex_ctrl;

  localparam int STEP = 4;
  localparam int DEB  = 4;
  localparam int XMIN = 285, XMAX = 1554, YMIN = 35, YMAX = 514;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset = 1'b1;
  logic [3:0]         key = 4'hF;
  logic               frame_start = 1'b0;
  logic signed [25:0] p1_x, p1_y, p2_x, p2_y, p3_x, p3_y;
  logic               updated;

  triangle_vertex_ctrl #(.STEP(STEP), .DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50(clk), .reset(reset), .KEY(key), .frame_start(frame_start),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y), .p3_x(p3_x), .p3_y(p3_y),
    .updated(updated)
  );

  int tests = 0;
  int errors = 0;
  int upd_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: vertices, expected update pulse, and the frame accepted but not yet committed.
  int mx[3], my[3], nx[3], ny[3];
  bit m_upd, pend, nchg;
  int due;
  logic [3:0] kh0 = 4'hF, kh1 = 4'hF;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    logic [3:0] pr;
    int dx, dy;
    pr  = ~kh1;
    kh1 = kh0;
    kh0 = key;
    if (reset) begin
      mx = '{300, 400, 600};
      my = '{100, 300, 200};
      m_upd = 1'b0;
      pend = 1'b0;
      kh0 = 4'hF;
      kh1 = 4'hF;
    end else begin
      m_upd = 1'b0;
      if (pend) begin
        due--;
        if (due == 0) begin
          mx = nx;
          my = ny;
          m_upd = nchg;
          pend = 1'b0;
        end
      end else if (frame_start) begin
        dx = 0;
        dy = 0;
        if (pr[0] && !pr[1])
          dx = imin(STEP, imax(0, XMAX - imax(mx[0], imax(mx[1], mx[2]))));
        else if (pr[1] && !pr[0])
          dx = -imin(STEP, imax(0, imin(mx[0], imin(mx[1], mx[2])) - XMIN));
        if (pr[2] && !pr[3])
          dy = imin(STEP, imax(0, YMAX - imax(my[0], imax(my[1], my[2]))));
        else if (pr[3] && !pr[2])
          dy = -imin(STEP, imax(0, imin(my[0], imin(my[1], my[2])) - YMIN));
        for (int i = 0; i < 3; i++) begin
          nx[i] = mx[i] + dx;
          ny[i] = my[i] + dy;
        end
        nchg = (dx != 0) || (dy != 0);
        pend = 1'b1;
        due = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("p1_x", int'(p1_x), mx[0]);
      check("p1_y", int'(p1_y), my[0]);
      check("p2_x", int'(p2_x), mx[1]);
      check("p2_y", int'(p2_y), my[1]);
      check("p3_x", int'(p3_x), mx[2]);
      check("p3_y", int'(p3_y), my[2]);
      check("updated", int'(updated), int'(m_upd));
      if (updated) upd_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    tick(4);
  endtask

  task automatic check_xy(input string nm, input int e1x, input int e1y, input int e2x,
                          input int e2y, input int e3x, input int e3y);
    check({nm, "_p1x"}, int'(p1_x), e1x);
    check({nm, "_p1y"}, int'(p1_y), e1y);
    check({nm, "_p2x"}, int'(p2_x), e2x);
    check({nm, "_p2y"}, int'(p2_y), e2y);
    check({nm, "_p3x"}, int'(p3_x), e3x);
    check({nm, "_p3y"}, int'(p3_y), e3y);
  endtask

  initial begin
    int u0, n, gap, lx;
    tick(3);
    chk_en = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    check_xy("reset", 300, 100, 400, 300, 600, 200);
    check("reset_upd", int'(updated), 0);
    $display("[TB] reset checked");

    // No keys, five frames.
    u0 = upd_seen;
    repeat (5) frame();
    check_xy("idle", 300, 100, 400, 300, 600, 200);
    check("idle_upd", upd_seen - u0, 0);
    $display("[TB] idle frames checked");

    // Right held for three frames; first one timed exactly.
    key = 4'b1110;
    tick(12);
    u0 = upd_seen;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk) check("lat_c2", int'(updated), 0);
    @(negedge clk) check("lat_c3", int'(updated), 1);
    @(negedge clk) check("lat_c4", int'(updated), 0);
    tick(2);
    frame();
    frame();
    check_xy("right3", 312, 100, 412, 300, 612, 200);
    check("right3_upd", upd_seen - u0, 3);
    $display("[TB] right x3 checked");

    // Left+right cancel, down moves.
    key = 4'b1000;
    tick(12);
    frame();
    check_xy("diag", 312, 104, 412, 304, 612, 204);
    $display("[TB] opposing x plus down checked");

    // Right clamp: final partial step of 2.
    key = 4'b1110;
    tick(12);
    repeat (240) frame();
    check_xy("rclamp", 1254, 104, 1354, 304, 1554, 204);
    u0 = upd_seen;
    frame();
    check("rclamp_noupd", upd_seen - u0, 0);
    $display("[TB] right clamp checked");

    // Up clamp: miny 104 -> 35.
    key = 4'b0111;
    tick(12);
    repeat (20) frame();
    check_xy("uclamp", 1254, 35, 1354, 235, 1554, 135);
    $display("[TB] up clamp checked");

    // Three-cycle glitch on KEY[1].
    key = 4'hF;
    tick(12);
`ifdef DEBOUNCE_EN
    @(negedge clk) key[1] = 1'b0;
    tick(3);
    key[1] = 1'b1;
    tick(12);
    frame();
    lx = 1254;
`else
    @(negedge clk) key[1] = 1'b0;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    key[1] = 1'b1;
    tick(12);
    lx = 1250;
`endif
    check("glitch_p1x", int'(p1_x), lx);
    $display("[TB] glitch checked");

    // Ten-cycle hold on KEY[1] moves left once.
    @(negedge clk) key[1] = 1'b0;
    tick(8);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(1);
    key[1] = 1'b1;
    tick(12);
    check("hold_p1x", int'(p1_x), lx - 4);
    check("hold_p3x", int'(p3_x), lx + 296);
    $display("[TB] held left checked");

    // Reset landing on the commit edge.
    key = 4'b1110;
    tick(12);
    u0 = upd_seen;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_xy("rstcommit", 300, 100, 400, 300, 600, 200);
    tick(4);
    check("rstcommit_noupd", upd_seen - u0, 0);
    key = 4'hF;
    tick(12);
    $display("[TB] reset during commit checked");

    // Random keys, occasional resets, bursts of closely spaced frame pulses.
    for (int it = 0; it < 60; it++) begin
      key = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
      tick(12);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        gap = $urandom_range(0, 4);
        tick(gap);
      end
      tick(6);
      $display("[TB] random iter %0d key=%b p1=(%0d,%0d)", it, key, p1_x, p1_y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
